instr_fetch: RTL and testbench

Instruction fetch stage sitting directly upstream of `control`. It owns the program counter, issues word fetches to instruction memory over a valid/ready request and valid-only response interface, and holds the fetched instruction in a one-entry output register. The output register drives `out_opcode` into `control` and the rest of decode. The stage honours a downstream stall and a redirect from branch/jump resolution, and discards any in-flight response that a redirect makes stale.

---
 rtl/instr_fetch_pkg.sv | 24 ++
 rtl/instr_fetch_pc_gen.sv | 22 ++
 rtl/instr_fetch.sv | 141 ++++++++++++++
 tb/tb_instr_fetch.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_fetch_pkg.sv
// Shared fetch-stage definitions: fetch FSM states, NOP encoding and RV32I major opcodes.
package instr_fetch_pkg;

  typedef enum logic [1:0] {
    S_FETCH   = 2'd0,
    S_WAIT    = 2'd1,
    S_DISCARD = 2'd2
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0013;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  function automatic logic is_misaligned(input logic [31:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/instr_fetch_pc_gen.sv
// Program counter register with hold / +4 / redirect next-PC selection.
module pc_gen #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pc_load,
  input  logic        pc_inc,
  input  logic [31:0] load_pc,
  output logic [31:0] pc
);

  always_ff @(posedge clk) begin
    if (rst)
      pc <= RESET_PC;
    else if (pc_load)
      pc <= load_pc;
    else if (pc_inc)
      pc <= pc + 32'd4;
  end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: PC ownership, single-outstanding imem requests, one-entry output register.
// Optional misaligned-fetch marker generation is enabled by defining IF_MISALIGN_TRAP_EN.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic        out_valid,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr,
  output logic [6:0]  out_opcode,
  output logic        out_misaligned
);

  fetch_state_e state, state_next;
  logic [31:0]  pc;
  logic [31:0]  redirect_target;
  logic         out_free;
  logic         pc_inc;
  logic         load_fetch;
  logic         load_trap;
  logic         pc_misaligned;
  logic         trap_done;

  assign out_free   = !out_valid || !stall;
  assign imem_addr  = pc;
  assign out_opcode = out_instr[6:0];

`ifdef IF_MISALIGN_TRAP_EN
  logic misaligned_q;

  assign redirect_target = redirect_pc;
  assign pc_misaligned   = is_misaligned(pc);
  assign out_misaligned  = misaligned_q;

  // trap_done keeps a parked misaligned PC from emitting a stream of markers
  always_ff @(posedge clk) begin
    if (rst || redirect_valid) begin
      misaligned_q <= 1'b0;
      trap_done    <= 1'b0;
    end else if (load_fetch) begin
      misaligned_q <= 1'b0;
    end else if (load_trap) begin
      misaligned_q <= 1'b1;
      trap_done    <= 1'b1;
    end
  end
`else
  assign redirect_target = redirect_pc & 32'hFFFF_FFFC;
  assign pc_misaligned   = 1'b0;
  assign trap_done       = 1'b0;
  assign out_misaligned  = 1'b0;
`endif

  pc_gen #(
    .RESET_PC(RESET_PC)
  ) u_pc_gen (
    .clk     (clk),
    .rst     (rst),
    .pc_load (redirect_valid),
    .pc_inc  (pc_inc),
    .load_pc (redirect_target),
    .pc      (pc)
  );

  always_comb begin
    state_next     = state;
    imem_req_valid = 1'b0;
    pc_inc         = 1'b0;
    load_fetch     = 1'b0;
    load_trap      = 1'b0;
    case (state)
      S_FETCH: begin
        if (pc_misaligned) begin
          load_trap = out_free && !redirect_valid && !trap_done && !rst;
        end else begin
          imem_req_valid = out_free && !redirect_valid && !rst;
          if (imem_req_valid && imem_req_ready)
            state_next = S_WAIT;
        end
      end
      S_WAIT: begin
        if (imem_rsp_valid) begin
          state_next = S_FETCH;
          if (!redirect_valid) begin
            pc_inc     = 1'b1;
            load_fetch = 1'b1;
          end
        end else if (redirect_valid) begin
          state_next = S_DISCARD;
        end
      end
      S_DISCARD: begin
        if (imem_rsp_valid)
          state_next = S_FETCH;
      end
      default: state_next = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)
      state <= S_FETCH;
    else
      state <= state_next;
  end

  // redirect flushes ahead of any load; a load on a consuming edge replaces the entry
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_pc    <= RESET_PC;
      out_instr <= NOP_INSTR;
    end else if (redirect_valid) begin
      out_valid <= 1'b0;
      out_instr <= NOP_INSTR;
    end else if (load_fetch) begin
      out_valid <= 1'b1;
      out_pc    <= pc;
      out_instr <= imem_rsp_data;
    end else if (load_trap) begin
      out_valid <= 1'b1;
      out_pc    <= pc;
      out_instr <= NOP_INSTR;
    end else if (out_valid && !stall) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: stimulus queues expected fetch addresses and outputs, a monitor checks them.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data  = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc    = '0;
  logic        stall          = 1'b0;
  logic        out_valid;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic [6:0]  out_opcode;
  logic        out_misaligned;

  always #5 clk = ~clk;

  instr_fetch #(
    .RESET_PC (32'h0000_0000),
    .NOP_INSTR(32'h0000_0013)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .imem_req_valid(imem_req_valid),
    .imem_req_ready(imem_req_ready),
    .imem_addr     (imem_addr),
    .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data (imem_rsp_data),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .stall         (stall),
    .out_valid     (out_valid),
    .out_pc        (out_pc),
    .out_instr     (out_instr),
    .out_opcode    (out_opcode),
    .out_misaligned(out_misaligned)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        mis;
  } out_t;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_addr_q[$];
  out_t        exp_out_q[$];
  int          out_times[$];
  int          cyc = 0;
  int          budget = 0;
  int          lat = 1;
  out_t        mon_e;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Memory contents: addr 0 holds an R-type word, others hold (addr << 12) | addi opcode
  function automatic logic [31:0] memword(input logic [31:0] a);
    if (a == 32'h0) return 32'h0000_0033;
    return (a << 12) | 32'h0000_0013;
  endfunction

  // Memory model: accepts while budget remains, answers 'lat' cycles after acceptance
  initial begin
    logic        acc;
    logic        rst_s;
    logic [31:0] a;
    logic [31:0] pa;
    int          cnt;
    cnt = 0;
    pa  = '0;
    forever begin
      @(negedge clk);
      acc   = imem_req_valid && imem_req_ready;
      a     = imem_addr;
      rst_s = rst;
      @(posedge clk);
      #2;
      imem_rsp_valid = 1'b0;
      if (rst_s) begin
        cnt = 0;
        acc = 1'b0;
      end
      if (acc) begin
        budget--;
        cnt = lat;
        pa  = a;
      end
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          imem_rsp_valid = 1'b1;
          imem_rsp_data  = memword(pa);
        end
      end
      imem_req_ready = (budget > 0);
    end
  end

  // Monitor: every accepted request and every consumed output entry is checked against the queues
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (imem_req_valid && imem_req_ready) begin
          if (exp_addr_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_req: got addr %h expected no request", imem_addr);
          end else begin
            chk("req_addr", imem_addr, exp_addr_q.pop_front());
          end
        end
        if (out_valid && !stall) begin
          out_times.push_back(cyc);
          if (exp_out_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_out: got pc %h instr %h expected no output", out_pc, out_instr);
          end else begin
            mon_e = exp_out_q.pop_front();
            chk("out_pc", out_pc, mon_e.pc);
            chk("out_instr", out_instr, mon_e.instr);
            chk("out_opcode", {25'b0, out_opcode}, {25'b0, mon_e.instr[6:0]});
            chk("out_misaligned", {31'b0, out_misaligned}, {31'b0, mon_e.mis});
          end
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got no finish expected finish before timeout");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst            = 1'b1;
    stall          = 1'b0;
    redirect_valid = 1'b0;
    budget         = 0;
    lat            = 1;
    @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", {31'b0, out_valid}, 32'h0);
    chk("rst_out_pc", out_pc, 32'h0);
    chk("rst_out_instr", out_instr, 32'h0000_0013);
    chk("rst_out_opcode", {25'b0, out_opcode}, 32'h13);
    chk("rst_out_misaligned", {31'b0, out_misaligned}, 32'h0);
    chk("rst_req_valid", {31'b0, imem_req_valid}, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_addr_q.size() != 0 || exp_out_q.size() != 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (exp_addr_q.size() != 0 || exp_out_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: got %0d addrs %0d outs pending expected 0 0",
               exp_addr_q.size(), exp_out_q.size());
      exp_addr_q.delete();
      exp_out_q.delete();
    end
    repeat (6) @(negedge clk);
  endtask

  task automatic wait_accept();
    int n;
    n = 0;
    @(negedge clk);
    while (!(imem_req_valid && imem_req_ready) && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!(imem_req_valid && imem_req_ready)) begin
      errors++;
      $display("FAIL accept_timeout: got no acceptance expected acceptance");
    end
  endtask

  task automatic wait_out_valid();
    int n;
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("out_valid_arrives", {31'b0, out_valid}, 32'h1);
  endtask

  initial begin
    // Reset release and first-fetch latency
    do_reset();
    budget = 1;
    exp_addr_q.push_back(32'h0);
    exp_out_q.push_back('{pc: 32'h0, instr: 32'h0000_0033, mis: 1'b0});
    @(negedge clk);
    chk("first_req_valid", {31'b0, imem_req_valid}, 32'h1);
    chk("first_req_addr", imem_addr, 32'h0);
    @(negedge clk);
    chk("latency_edge1_valid", {31'b0, out_valid}, 32'h0);
    @(negedge clk);
    chk("latency_edge2_valid", {31'b0, out_valid}, 32'h1);
    chk("first_opcode", {25'b0, out_opcode}, 32'h33);
    drain();

    // Straight-line fetch at one instruction per two cycles
    do_reset();
    budget = 3;
    out_times.delete();
    exp_addr_q.push_back(32'h0);
    exp_addr_q.push_back(32'h4);
    exp_addr_q.push_back(32'h8);
    exp_out_q.push_back('{pc: 32'h0, instr: 32'h0000_0033, mis: 1'b0});
    exp_out_q.push_back('{pc: 32'h4, instr: 32'h0000_4013, mis: 1'b0});
    exp_out_q.push_back('{pc: 32'h8, instr: 32'h0000_8013, mis: 1'b0});
    drain();
    chk("straight_out_count", out_times.size(), 32'd3);
    if (out_times.size() == 3) begin
      chk("spacing_0_1", out_times[1] - out_times[0], 32'd2);
      chk("spacing_1_2", out_times[2] - out_times[1], 32'd2);
    end

    // Stall holds the entry and blocks further requests
    do_reset();
    budget = 2;
    stall  = 1'b1;
    exp_addr_q.push_back(32'h0);
    exp_addr_q.push_back(32'h4);
    exp_out_q.push_back('{pc: 32'h0, instr: 32'h0000_0033, mis: 1'b0});
    exp_out_q.push_back('{pc: 32'h4, instr: 32'h0000_4013, mis: 1'b0});
    wait_out_valid();
    for (int i = 0; i < 3; i++) begin
      chk("stall_instr_stable", out_instr, 32'h0000_0033);
      chk("stall_no_req", {31'b0, imem_req_valid}, 32'h0);
      @(posedge clk);
      #1;
    end
    stall = 1'b0;
    @(negedge clk);
    chk("post_stall_req_valid", {31'b0, imem_req_valid}, 32'h1);
    chk("post_stall_req_addr", imem_addr, 32'h4);
    drain();

    // Redirect while waiting: stale response discarded
    do_reset();
    budget = 2;
    lat    = 3;
    exp_addr_q.push_back(32'h0);
    exp_addr_q.push_back(32'h100);
    exp_out_q.push_back('{pc: 32'h100, instr: 32'h0010_0013, mis: 1'b0});
    wait_accept();
    @(posedge clk);
    #1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h100;
    @(posedge clk);
    #1;
    redirect_valid = 1'b0;
    @(negedge clk);
    chk("discard_no_req", {31'b0, imem_req_valid}, 32'h0);
    chk("discard_out_valid", {31'b0, out_valid}, 32'h0);
    drain();

    // Redirect coincident with the response: straight back to FETCH
    do_reset();
    budget = 2;
    exp_addr_q.push_back(32'h0);
    exp_addr_q.push_back(32'h200);
    exp_out_q.push_back('{pc: 32'h200, instr: 32'h0020_0013, mis: 1'b0});
    wait_accept();
    @(posedge clk);
    #1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h200;
    @(posedge clk);
    #1;
    redirect_valid = 1'b0;
    @(negedge clk);
    chk("simul_req_valid", {31'b0, imem_req_valid}, 32'h1);
    chk("simul_req_addr", imem_addr, 32'h200);
    drain();

    // PC wrap at the top of the address space
    do_reset();
    budget         = 2;
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    exp_addr_q.push_back(32'hFFFF_FFFC);
    exp_addr_q.push_back(32'h0);
    exp_out_q.push_back('{pc: 32'hFFFF_FFFC, instr: 32'hFFFF_C013, mis: 1'b0});
    exp_out_q.push_back('{pc: 32'h0, instr: 32'h0000_0033, mis: 1'b0});
    @(posedge clk);
    #1;
    redirect_valid = 1'b0;
    drain();

    // Misaligned redirect target
    do_reset();
    budget         = 1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h102;
`ifdef IF_MISALIGN_TRAP_EN
    exp_out_q.push_back('{pc: 32'h102, instr: 32'h0000_0013, mis: 1'b1});
`else
    exp_addr_q.push_back(32'h100);
    exp_out_q.push_back('{pc: 32'h100, instr: 32'h0010_0013, mis: 1'b0});
`endif
    @(posedge clk);
    #1;
    redirect_valid = 1'b0;
    @(negedge clk);
`ifdef IF_MISALIGN_TRAP_EN
    chk("misalign_no_req", {31'b0, imem_req_valid}, 32'h0);
`else
    chk("aligned_req_addr", imem_addr, 32'h100);
`endif
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
